// File: rtl/router_merge_pkg.sv
// Shared types and sizing for the four-to-one return-path merge.
// ROUTER_MERGE_FIXED_PRIO_EN selects fixed-priority arbitration; round-robin otherwise.
package router_merge_pkg;
  localparam int DATA_WIDTH = 32;
  localparam int NUM_PORTS  = 4;
  localparam int ADDR_W     = 2;

  typedef logic [ADDR_W-1:0]     port_idx_t;
  typedef logic [DATA_WIDTH-1:0] data_t;
endpackage

// File: rtl/router_merge_if.sv
// Bundle of the four source ports and the merged output; slave is the merge block's view.
// Source side is valid/ready with one word in flight per port, output side is valid/ready.
interface router_merge_if;
  import router_merge_pkg::*;

  data_t     din0, din1, din2, din3;
  logic      din_en0, din_en1, din_en2, din_en3;
  logic      din_rdy0, din_rdy1, din_rdy2, din_rdy3;
  data_t     dout;
  logic      dout_en;
  port_idx_t dout_addr;
  logic      dout_rdy;

  modport slave (
    input  din0, din1, din2, din3,
    input  din_en0, din_en1, din_en2, din_en3,
    output din_rdy0, din_rdy1, din_rdy2, din_rdy3,
    output dout, dout_en, dout_addr,
    input  dout_rdy
  );

  modport master (
    output din0, din1, din2, din3,
    output din_en0, din_en1, din_en2, din_en3,
    input  din_rdy0, din_rdy1, din_rdy2, din_rdy3,
    input  dout, dout_en, dout_addr,
    output dout_rdy
  );
endinterface

// File: rtl/router_merge_rr_arbiter.sv
// Four-way arbiter, combinational grant; round-robin from last_grant+1, or fixed
// priority (port 0 highest) when ROUTER_MERGE_FIXED_PRIO_EN is defined. No grant while en is low.
module rr_arbiter
  import router_merge_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 en,
  output logic [NUM_PORTS-1:0] gnt,
  output port_idx_t            gnt_idx
);

`ifdef ROUTER_MERGE_FIXED_PRIO_EN
  // Walk from the lowest-priority port upward so port 0 overrides everything.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) begin
      if (en && req[k]) begin
        gnt     = '0;
        gnt[k]  = 1'b1;
        gnt_idx = port_idx_t'(k);
      end
    end
  end
`else
  port_idx_t last_grant;
  port_idx_t cand;
  logic      found;

  // Index arithmetic is ADDR_W bits wide, so the search wraps 3 -> 0 naturally.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      cand = last_grant + port_idx_t'(k + 1);
      if (en && !found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant <= port_idx_t'(NUM_PORTS - 1);
    end else if (|gnt) begin
      last_grant <= gnt_idx;
    end
  end
`endif

endmodule

// File: rtl/router_merge.sv
// Merges four sources onto one output tagged with the source index; 2 edges input-to-output.
// Output holds while dout_rdy is low; each source buffer stalls (din_rdy low) until drained.
module router_merge
  import router_merge_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  router_merge_if.slave  bus
);

  data_t                din_dat [NUM_PORTS];
  logic [NUM_PORTS-1:0] din_vld;
  data_t                buf_dat [NUM_PORTS];
  logic [NUM_PORTS-1:0] buf_vld;
  logic [NUM_PORTS-1:0] gnt;
  port_idx_t            gnt_idx;
  logic                 out_free;

  data_t                dout_q;
  logic                 dout_en_q;
  port_idx_t            dout_addr_q;

  assign din_dat[0] = bus.din0;
  assign din_dat[1] = bus.din1;
  assign din_dat[2] = bus.din2;
  assign din_dat[3] = bus.din3;
  assign din_vld    = {bus.din_en3, bus.din_en2, bus.din_en1, bus.din_en0};

  // Ready depends only on buffer occupancy, so a drained buffer refills one cycle later.
  assign bus.din_rdy0 = !buf_vld[0];
  assign bus.din_rdy1 = !buf_vld[1];
  assign bus.din_rdy2 = !buf_vld[2];
  assign bus.din_rdy3 = !buf_vld[3];

  assign out_free = !dout_en_q || bus.dout_rdy;

  rr_arbiter u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (buf_vld),
    .en      (out_free),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  // Load and drain are exclusive per port: a grant needs buf_vld, a load needs !buf_vld.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_vld <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (din_vld[i] && !buf_vld[i]) begin
          buf_vld[i] <= 1'b1;
        end else if (gnt[i]) begin
          buf_vld[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (din_vld[i] && !buf_vld[i]) begin
        buf_dat[i] <= din_dat[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dout_q      <= '0;
      dout_en_q   <= 1'b0;
      dout_addr_q <= '0;
    end else if (|gnt) begin
      dout_q      <= buf_dat[gnt_idx];
      dout_en_q   <= 1'b1;
      dout_addr_q <= gnt_idx;
    end else if (out_free) begin
      dout_en_q   <= 1'b0;
    end
  end

  assign bus.dout      = dout_q;
  assign bus.dout_en   = dout_en_q;
  assign bus.dout_addr = dout_addr_q;

endmodule

// File: tb/tb_router_merge.sv
// Directed bench for router_merge: reset, latency, ordering, back-pressure, wrap fairness, mid-run reset.
`timescale 1ns/1ps
module tb_router_merge;
  logic clk;
  logic reset;
  int   checks;
  int   errors;

  router_merge_if bus ();

  router_merge dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic en, input logic [1:0] addr, input logic [31:0] dat);
    check({tag, "_en"}, {31'd0, bus.dout_en}, {31'd0, en});
    check({tag, "_addr"}, {30'd0, bus.dout_addr}, {30'd0, addr});
    check({tag, "_dat"}, bus.dout, dat);
  endtask

  task automatic check_rdy(input string tag, input logic [3:0] exp);
    check(tag, {28'd0, bus.din_rdy3, bus.din_rdy2, bus.din_rdy1, bus.din_rdy0}, {28'd0, exp});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.din0 = '0; bus.din1 = '0; bus.din2 = '0; bus.din3 = '0;
    bus.din_en0 = 1'b0; bus.din_en1 = 1'b0; bus.din_en2 = 1'b0; bus.din_en3 = 1'b0;
    bus.dout_rdy = 1'b1;

    // Reset state
    cyc();
    cyc();
    check_out("reset", 1'b0, 2'd0, 32'h0);
    check_rdy("reset_rdy", 4'b1111);
    reset = 1'b0;

    // Single word latency from port 0
    bus.din0 = 32'hA5A5A5A5;
    bus.din_en0 = 1'b1;
    cyc();
    bus.din_en0 = 1'b0;
    check_rdy("lat_rdy_low", 4'b1110);
    check("lat_en_early", {31'd0, bus.dout_en}, 32'd0);
    cyc();
    check_out("lat_out", 1'b1, 2'd0, 32'hA5A5A5A5);
    check_rdy("lat_rdy_back", 4'b1111);
    cyc();
    check("lat_en_clear", {31'd0, bus.dout_en}, 32'd0);

    // Four ports loaded at once, fresh priority: order 0,1,2,3
    do_reset();
    bus.din0 = 32'h10; bus.din1 = 32'h11; bus.din2 = 32'h12; bus.din3 = 32'h13;
    bus.din_en0 = 1'b1; bus.din_en1 = 1'b1; bus.din_en2 = 1'b1; bus.din_en3 = 1'b1;
    cyc();
    bus.din_en0 = 1'b0; bus.din_en1 = 1'b0; bus.din_en2 = 1'b0; bus.din_en3 = 1'b0;
    check_rdy("all_rdy_low", 4'b0000);
    cyc();
    check_out("all_0", 1'b1, 2'd0, 32'h10);
    cyc();
    check_out("all_1", 1'b1, 2'd1, 32'h11);
    cyc();
    check_out("all_2", 1'b1, 2'd2, 32'h12);
    cyc();
    check_out("all_3", 1'b1, 2'd3, 32'h13);
    cyc();
    check("all_idle", {31'd0, bus.dout_en}, 32'd0);

    // Back-pressure: output held, refilled buffer 2 stays blocked
    bus.dout_rdy = 1'b0;
    bus.din2 = 32'h22;
    bus.din_en2 = 1'b1;
    cyc();
    bus.din_en2 = 1'b0;
    cyc();
    check_out("bp_first", 1'b1, 2'd2, 32'h22);
    bus.din2 = 32'h23;
    bus.din_en2 = 1'b1;
    cyc();
    bus.din_en2 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check_out($sformatf("bp_hold%0d", i), 1'b1, 2'd2, 32'h22);
      check_rdy($sformatf("bp_rdy%0d", i), 4'b1011);
      cyc();
    end
    check_out("bp_still", 1'b1, 2'd2, 32'h22);
    bus.dout_rdy = 1'b1;
    cyc();
    check_out("bp_next", 1'b1, 2'd2, 32'h23);
    check_rdy("bp_rdy_free", 4'b1111);
    cyc();
    check("bp_idle", {31'd0, bus.dout_en}, 32'd0);

    // Set last grant to 3, then ports 0 and 3 stream continuously
    bus.din3 = 32'h30;
    bus.din_en3 = 1'b1;
    cyc();
    bus.din_en3 = 1'b0;
    cyc();
    check_out("wrap_prime", 1'b1, 2'd3, 32'h30);
    cyc();
    bus.din0 = 32'h40; bus.din3 = 32'h43;
    bus.din_en0 = 1'b1; bus.din_en3 = 1'b1;
    cyc();
    check("wrap_en_early", {31'd0, bus.dout_en}, 32'd0);
    cyc();
    check_out("wrap_g0", 1'b1, 2'd0, 32'h40);
    cyc();
    check_out("wrap_g1", 1'b1, 2'd3, 32'h43);
    cyc();
    check_out("wrap_g2", 1'b1, 2'd0, 32'h40);
    cyc();
    check_out("wrap_g3", 1'b1, 2'd3, 32'h43);
    bus.din_en0 = 1'b0; bus.din_en3 = 1'b0;
    cyc();
    check_out("wrap_tail", 1'b1, 2'd0, 32'h40);
    cyc();
    check("wrap_idle", {31'd0, bus.dout_en}, 32'd0);

    // Reset while output valid and buffers 2,3 full
    bus.dout_rdy = 1'b0;
    bus.din1 = 32'h51;
    bus.din_en1 = 1'b1;
    cyc();
    bus.din_en1 = 1'b0;
    cyc();
    check_out("rst_pre_out", 1'b1, 2'd1, 32'h51);
    bus.din2 = 32'h52; bus.din3 = 32'h53;
    bus.din_en2 = 1'b1; bus.din_en3 = 1'b1;
    cyc();
    bus.din_en2 = 1'b0; bus.din_en3 = 1'b0;
    check_rdy("rst_pre_rdy", 4'b0011);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check_out("rst_out", 1'b0, 2'd0, 32'h0);
    check_rdy("rst_rdy", 4'b1111);
    bus.dout_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      check($sformatf("rst_nostale%0d", i), {31'd0, bus.dout_en}, 32'd0);
    end

    // Ports 0 and 1 streaming: port 1 wins only while buffer 0 refills
    bus.din0 = 32'h60; bus.din1 = 32'h61;
    bus.din_en0 = 1'b1; bus.din_en1 = 1'b1;
    cyc();
    cyc();
    check_out("alt_g0", 1'b1, 2'd0, 32'h60);
    check_rdy("alt_rdy0", 4'b1101);
    cyc();
    check_out("alt_g1", 1'b1, 2'd1, 32'h61);
    cyc();
    check_out("alt_g2", 1'b1, 2'd0, 32'h60);
    cyc();
    check_out("alt_g3", 1'b1, 2'd1, 32'h61);
    bus.din_en0 = 1'b0; bus.din_en1 = 1'b0;
    cyc();
    cyc();
    cyc();
    check("alt_idle", {31'd0, bus.dout_en}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
